// File: rtl/intersection_ctrl.sv
// Purpose: two-way traffic light sequencer with all-red clearance, latched walk phase, night flash.
// Latency: lamps decode from registered state only; phases hold exactly T_* cycles.
// Backpressure: none; PedReq is latched and Night is sampled at all-red expiry.
module intersection_ctrl #(
    parameter int CNT_W        = 32,
    parameter int T_ALL_RED    = 25_000_000,
    parameter int T_RED_YELLOW = 25_000_000,
    parameter int T_GREEN      = 150_000_000,
    parameter int T_YELLOW     = 50_000_000,
    parameter int T_WALK       = 100_000_000,
    parameter int T_FLASH      = 25_000_000
) (
    input  logic       Clock,
    input  logic       Reset_N,
    input  logic       PedReq,
    input  logic       Night,
    output logic       NsRed,
    output logic       NsYellow,
    output logic       NsGreen,
    output logic       EwRed,
    output logic       EwYellow,
    output logic       EwGreen,
    output logic       Walk,
    output logic       PedPending,
    output logic [3:0] PhaseState
);

    localparam logic [3:0] AR_A  = 4'd0;
    localparam logic [3:0] NS_RY = 4'd1;
    localparam logic [3:0] NS_G  = 4'd2;
    localparam logic [3:0] NS_Y  = 4'd3;
    localparam logic [3:0] AR_B  = 4'd4;
    localparam logic [3:0] EW_RY = 4'd5;
    localparam logic [3:0] EW_G  = 4'd6;
    localparam logic [3:0] EW_Y  = 4'd7;
    localparam logic [3:0] WALK  = 4'd8;
    localparam logic [3:0] FLASH = 4'd9;

    localparam logic [CNT_W-1:0] LAST_AR    = CNT_W'(T_ALL_RED - 1);
    localparam logic [CNT_W-1:0] LAST_RY    = CNT_W'(T_RED_YELLOW - 1);
    localparam logic [CNT_W-1:0] LAST_G     = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] LAST_Y     = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LAST_WALK  = CNT_W'(T_WALK - 1);
    localparam logic [CNT_W-1:0] LAST_FLASH = CNT_W'(T_FLASH - 1);

    logic [3:0]       state;
    logic [3:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_last;
    logic             next_dir;     // 0: WALK exits to NS, 1: WALK exits to EW
    logic             ped_pending;
    logic             flash_on;
    logic             expire;
    logic             all_red;
    logic             enter_walk;

    always_comb begin
        cnt_last = LAST_AR;
        case (state)
            AR_A, AR_B:   cnt_last = LAST_AR;
            NS_RY, EW_RY: cnt_last = LAST_RY;
            NS_G, EW_G:   cnt_last = LAST_G;
            NS_Y, EW_Y:   cnt_last = LAST_Y;
            WALK:         cnt_last = LAST_WALK;
            FLASH:        cnt_last = LAST_FLASH;
            default:      cnt_last = LAST_AR;
        endcase
    end

    assign expire     = (cnt == cnt_last);
    assign all_red    = (state == AR_A) || (state == AR_B);
    assign enter_walk = expire && all_red && !Night && ped_pending;

    always_comb begin
        state_nxt = AR_A;
        case (state)
            AR_A:    state_nxt = Night ? FLASH : (ped_pending ? WALK : NS_RY);
            NS_RY:   state_nxt = NS_G;
            NS_G:    state_nxt = NS_Y;
            NS_Y:    state_nxt = AR_B;
            AR_B:    state_nxt = Night ? FLASH : (ped_pending ? WALK : EW_RY);
            EW_RY:   state_nxt = EW_G;
            EW_G:    state_nxt = EW_Y;
            EW_Y:    state_nxt = AR_A;
            WALK:    state_nxt = next_dir ? EW_RY : NS_RY;
            default: state_nxt = AR_A;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            state       <= AR_A;
            cnt         <= '0;
            next_dir    <= 1'b0;
            ped_pending <= 1'b0;
            flash_on    <= 1'b0;
        end else begin
            // Entering WALK clears the latch even if PedReq is high on that edge.
            if (enter_walk)
                ped_pending <= 1'b0;
            else if (PedReq && state != WALK)
                ped_pending <= 1'b1;

            if (state == FLASH) begin
                if (!Night) begin
                    state    <= AR_A;
                    cnt      <= '0;
                    next_dir <= 1'b0;
                    flash_on <= 1'b0;
                end else if (expire) begin
                    cnt      <= '0;
                    flash_on <= ~flash_on;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (expire) begin
                cnt   <= '0;
                state <= state_nxt;
                if (state == AR_A) next_dir <= 1'b0;
                if (state == AR_B) next_dir <= 1'b1;
                if (state_nxt == FLASH) flash_on <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        NsRed    = 1'b1;
        NsYellow = 1'b0;
        NsGreen  = 1'b0;
        EwRed    = 1'b1;
        EwYellow = 1'b0;
        EwGreen  = 1'b0;
        Walk     = 1'b0;
        case (state)
            NS_RY: NsYellow = 1'b1;
            NS_G:  begin NsRed = 1'b0; NsGreen = 1'b1; end
            NS_Y:  begin NsRed = 1'b0; NsYellow = 1'b1; end
            EW_RY: EwYellow = 1'b1;
            EW_G:  begin EwRed = 1'b0; EwGreen = 1'b1; end
            EW_Y:  begin EwRed = 1'b0; EwYellow = 1'b1; end
            WALK:  Walk = 1'b1;
            FLASH: begin
                NsRed    = 1'b0;
                EwRed    = 1'b0;
                NsYellow = flash_on;
                EwYellow = flash_on;
            end
            default: ;
        endcase
    end

    assign PedPending = ped_pending;
    assign PhaseState = state;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed bench for intersection_ctrl: expected phases/lamps are queued per cycle and popped at each negedge.
module tb_intersection_ctrl;

    logic       Clock = 1'b0;
    logic       Reset_N = 1'b0;
    logic       PedReq = 1'b0;
    logic       Night = 1'b0;
    logic       NsRed, NsYellow, NsGreen, EwRed, EwYellow, EwGreen, Walk, PedPending;
    logic [3:0] PhaseState;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [3:0] ph;
        logic [6:0] lamps;   // {NsRed,NsYellow,NsGreen,EwRed,EwYellow,EwGreen,Walk}
        logic [1:0] pend;    // 0/1 expected, 2 = not checked
    } exp_t;

    exp_t sb[$];

    intersection_ctrl #(
        .CNT_W(8), .T_ALL_RED(2), .T_RED_YELLOW(2), .T_GREEN(5),
        .T_YELLOW(3), .T_WALK(4), .T_FLASH(3)
    ) dut (
        .Clock(Clock), .Reset_N(Reset_N), .PedReq(PedReq), .Night(Night),
        .NsRed(NsRed), .NsYellow(NsYellow), .NsGreen(NsGreen),
        .EwRed(EwRed), .EwYellow(EwYellow), .EwGreen(EwGreen),
        .Walk(Walk), .PedPending(PedPending), .PhaseState(PhaseState)
    );

    always #5 Clock = ~Clock;

    function automatic logic [6:0] lamp_tab(input logic [3:0] ph, input logic fl);
        case (ph)
            4'd0, 4'd4: return 7'b1001000;
            4'd1:       return 7'b1101000;
            4'd2:       return 7'b0011000;
            4'd3:       return 7'b0101000;
            4'd5:       return 7'b1001100;
            4'd6:       return 7'b1000010;
            4'd7:       return 7'b1000100;
            4'd8:       return 7'b1001001;
            default:    return {1'b0, fl, 1'b0, 1'b0, fl, 1'b0, 1'b0};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [3:0] ph, input int n, input logic fl, input logic [1:0] pend);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.ph = ph; e.lamps = lamp_tab(ph, fl); e.pend = pend;
            sb.push_back(e);
        end
    endtask

    task automatic push_ns_half(input logic [1:0] pend);
        push(4'd0, 2, 1'b0, pend);
        push(4'd1, 2, 1'b0, pend);
        push(4'd2, 5, 1'b0, pend);
        push(4'd3, 3, 1'b0, pend);
    endtask

    task automatic step(input string tag);
        exp_t e;
        @(negedge Clock);
        chk($sformatf("%s c%0d sb_nonempty", tag, cyc), 16'(sb.size() > 0), 16'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("%s c%0d phase", tag, cyc), 16'(PhaseState), 16'(e.ph));
            chk($sformatf("%s c%0d lamps", tag, cyc),
                16'({NsRed, NsYellow, NsGreen, EwRed, EwYellow, EwGreen, Walk}), 16'(e.lamps));
            if (e.pend != 2'd2)
                chk($sformatf("%s c%0d pending", tag, cyc), 16'(PedPending), 16'(e.pend[0]));
        end
        chk($sformatf("%s c%0d greens_exclusive", tag, cyc), 16'(NsGreen && EwGreen), 16'd0);
        chk($sformatf("%s c%0d walk_all_red", tag, cyc),
            16'(Walk && !(NsRed && EwRed && !NsGreen && !EwGreen)), 16'd0);
        cyc++;
    endtask

    task automatic do_reset(input string tag);
        PedReq  = 1'b0;
        Night   = 1'b0;
        Reset_N = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        chk({tag, " reset_phase"}, 16'(PhaseState), 16'd0);
        chk({tag, " reset_lamps"},
            16'({NsRed, NsYellow, NsGreen, EwRed, EwYellow, EwGreen, Walk}), 16'b1001000);
        chk({tag, " reset_pending"}, 16'(PedPending), 16'd0);
        Reset_N = 1'b1;
        sb.delete();
        cyc = 0;
    endtask

    task automatic end_test(input string tag);
        chk({tag, " sb_drained"}, 16'(sb.size()), 16'd0);
    endtask

    initial begin
        // Free run: two full 24-cycle periods.
        do_reset("free");
        for (int k = 0; k < 2; k++) begin
            push_ns_half(2'd0);
            push(4'd4, 2, 1'b0, 2'd0);
            push(4'd5, 2, 1'b0, 2'd0);
            push(4'd6, 5, 1'b0, 2'd0);
            push(4'd7, 3, 1'b0, 2'd0);
        end
        for (int i = 0; i < 48; i++) step("free");
        end_test("free");

        // Single-cycle pedestrian pulse at cycle 5.
        do_reset("ped");
        push(4'd0, 2, 1'b0, 2'd0);
        push(4'd1, 2, 1'b0, 2'd0);
        push(4'd2, 2, 1'b0, 2'd0);
        push(4'd2, 3, 1'b0, 2'd1);
        push(4'd3, 3, 1'b0, 2'd1);
        push(4'd4, 2, 1'b0, 2'd1);
        push(4'd8, 4, 1'b0, 2'd0);
        push(4'd5, 2, 1'b0, 2'd0);
        for (int i = 0; i < 20; i++) begin
            step("ped");
            PedReq = (i == 5);
        end
        PedReq = 1'b0;
        end_test("ped");

        // Night from cycle 6: NS half completes, flash, then back to AR_A.
        do_reset("night");
        push_ns_half(2'd0);
        push(4'd4, 2, 1'b0, 2'd0);
        push(4'd9, 3, 1'b1, 2'd0);
        push(4'd9, 3, 1'b0, 2'd0);
        push(4'd9, 3, 1'b1, 2'd0);
        push(4'd0, 2, 1'b0, 2'd0);
        push(4'd1, 1, 1'b0, 2'd0);
        for (int i = 0; i < 26; i++) begin
            step("night");
            if (i == 6)  Night = 1'b1;
            if (i == 22) Night = 1'b0;
        end
        end_test("night");

        // Pedestrian and night together: flash first, then walk, then NS.
        do_reset("both");
        push(4'd0, 2, 1'b0, 2'd0);
        push(4'd1, 2, 1'b0, 2'd0);
        push(4'd2, 5, 1'b0, 2'd1);
        push(4'd3, 3, 1'b0, 2'd1);
        push(4'd4, 2, 1'b0, 2'd1);
        push(4'd9, 3, 1'b1, 2'd1);
        push(4'd9, 2, 1'b0, 2'd1);
        push(4'd0, 2, 1'b0, 2'd1);
        push(4'd8, 4, 1'b0, 2'd0);
        push(4'd1, 2, 1'b0, 2'd0);
        push(4'd2, 1, 1'b0, 2'd0);
        for (int i = 0; i < 28; i++) begin
            step("both");
            PedReq = (i == 3);
            if (i == 3)  Night = 1'b1;
            if (i == 18) Night = 1'b0;
        end
        end_test("both");

        // PedReq held high through the whole walk phase.
        do_reset("hold");
        push(4'd0, 2, 1'b0, 2'd0);
        push(4'd1, 2, 1'b0, 2'd0);
        push(4'd2, 2, 1'b0, 2'd0);
        push(4'd2, 3, 1'b0, 2'd1);
        push(4'd3, 3, 1'b0, 2'd1);
        push(4'd4, 2, 1'b0, 2'd1);
        push(4'd8, 4, 1'b0, 2'd0);
        push(4'd5, 1, 1'b0, 2'd2);
        push(4'd5, 1, 1'b0, 2'd1);
        push(4'd6, 1, 1'b0, 2'd1);
        for (int i = 0; i < 21; i++) begin
            step("hold");
            PedReq = (i >= 5 && i <= 18);
        end
        PedReq = 1'b0;
        end_test("hold");

        // Asynchronous reset in the middle of NS green, then free-run timing repeats.
        do_reset("arst");
        push_ns_half(2'd0);
        for (int i = 0; i < 6; i++) step("arst");
        #2;
        Reset_N = 1'b0;
        #1;
        chk("arst async_lamps",
            16'({NsRed, NsYellow, NsGreen, EwRed, EwYellow, EwGreen, Walk}), 16'b1001000);
        chk("arst async_phase", 16'(PhaseState), 16'd0);
        do_reset("arst2");
        push_ns_half(2'd0);
        push(4'd4, 2, 1'b0, 2'd0);
        push(4'd5, 2, 1'b0, 2'd0);
        push(4'd6, 5, 1'b0, 2'd0);
        push(4'd7, 3, 1'b0, 2'd0);
        push(4'd0, 1, 1'b0, 2'd0);
        for (int i = 0; i < 25; i++) step("arst2");
        end_test("arst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
